// File: rtl/mem_access_stage_pkg.sv
// mem_access_stage_pkg: shared MEM-stage control-bit indices and FSM state encoding
package mem_access_stage_pkg;
    localparam int MEMREAD  = 1;
    localparam int MEMWRITE = 0;
    localparam int REGWRITE = 1;
    localparam int MEMTOREG = 0;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
endpackage

// File: rtl/mem_access_stage_counter.sv
// mem_timeout_counter: counts BUSY cycles without ack, flags the last allowed cycle
// Ports: clk, reset (sync, active-high), clear (zero count), enable (increment),
//        terminal (count == TIMEOUT-1)
import mem_access_stage_pkg::*;
module mem_timeout_counter #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);
    logic [CNT_W-1:0] count;
    always_ff @(posedge clk) begin
        if (reset || clear) count <= '0;
        else if (enable) count <= count + 1'b1;
    end
    assign terminal = (count == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM-stage load/store engine on a req/ack data bus with stall, fault and timeout
// Ports: EX/MEM inputs (M_control_in, WB_control_in, ALU_out_in, data_write_in, rw_in),
//        stall to upstream, registered dmem_req/we/addr/wdata bus outputs with dmem_ack/rdata,
//        registered MEM/WB outputs (WB_control_out, ALU_out_out, mem_data_out, rw_out), bus_error pulse
import mem_access_stage_pkg::*;
module mem_access_stage #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  M_control_in,
    input  logic [1:0]  WB_control_in,
    input  logic [31:0] ALU_out_in,
    input  logic [31:0] data_write_in,
    input  logic [4:0]  rw_in,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [1:0]  WB_control_out,
    output logic [31:0] ALU_out_out,
    output logic [31:0] mem_data_out,
    output logic [4:0]  rw_out,
    output logic        bus_error
);
    state_t state, state_n;
    logic access, fault, start, ack, abort, terminal;
    assign access = |M_control_in;
    assign fault  = &M_control_in || (access && |ALU_out_in[1:0]);
    assign start  = (state == IDLE) && access && !fault;
    assign ack    = (state == BUSY) && dmem_ack;
    assign abort  = (state == BUSY) && !dmem_ack && terminal;
    // the abort cycle releases the pipeline so the bubbled instruction leaves with the error
    assign stall  = !reset && (start || ((state == BUSY) && !dmem_ack && !terminal));

    mem_timeout_counter #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clear    (state == IDLE),
        .enable   ((state == BUSY) && !dmem_ack),
        .terminal (terminal)
    );

    always_comb begin
        state_n = start ? BUSY : (ack || abort) ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            WB_control_out <= '0;
            ALU_out_out    <= '0;
            mem_data_out   <= '0;
            rw_out         <= '0;
            bus_error      <= 1'b0;
        end else begin
            state     <= state_n;
            bus_error <= ((state == IDLE) && fault) || abort;
            if (start) begin
                dmem_req   <= 1'b1;
                dmem_we    <= M_control_in[MEMWRITE];
                dmem_addr  <= {ALU_out_in[31:2], 2'b00};
                dmem_wdata <= data_write_in;
            end else if (ack || abort) begin
                dmem_req <= 1'b0;
            end
            // only a clean ALU op or a completed access commits; everything else is a bubble
            WB_control_out <= (((state == IDLE) && !access) || ack) ? WB_control_in : '0;
            if ((state == IDLE) || ack) begin
                ALU_out_out <= ALU_out_in;
                rw_out      <= rw_in;
            end
            mem_data_out <= (ack && !dmem_we) ? dmem_rdata : '0;
        end
    end
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: randomized transaction-level check of mem_access_stage against a reference model
module tb_mem_access_stage;
    localparam int TIMEOUT = 4;
    logic        clk = 0;
    logic        reset;
    logic [1:0]  M_control_in, WB_control_in, WB_control_out;
    logic [31:0] ALU_out_in, data_write_in, dmem_addr, dmem_wdata, dmem_rdata, ALU_out_out, mem_data_out;
    logic [4:0]  rw_in, rw_out;
    logic        stall, dmem_req, dmem_we, dmem_ack, bus_error;
    int checks = 0, failures = 0;

    mem_access_stage #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .M_control_in(M_control_in), .WB_control_in(WB_control_in),
        .ALU_out_in(ALU_out_in), .data_write_in(data_write_in), .rw_in(rw_in), .stall(stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .WB_control_out(WB_control_out),
        .ALU_out_out(ALU_out_out), .mem_data_out(mem_data_out), .rw_out(rw_out), .bus_error(bus_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // One instruction presented by an upstream that holds while stalled; memory acks
    // after d idle BUSY cycles. Expectations come from the instruction's class alone.
    task automatic issue(input logic [1:0] m, input logic [1:0] wb, input logic [31:0] addr,
                         input logic [31:0] data, input logic [4:0] rw, input int d, input logic [31:0] rd);
        int bc = 0, st = 0, n = 0, exp_st;
        logic s;
        bit acc, flt, ok, tmo, bad;
        acc = (m != 2'b00);
        flt = (m == 2'b11) || (acc && addr[1:0] != 2'b00);
        ok  = acc && !flt;
        tmo = ok && (d >= TIMEOUT);
        bad = flt || tmo;
        exp_st = !ok ? 0 : tmo ? TIMEOUT : d + 1;
        @(negedge clk);
        M_control_in = m; WB_control_in = wb; ALU_out_in = addr; data_write_in = data; rw_in = rw;
        do begin
            if (n > 0) begin
                @(negedge clk);
                check("wb_bubble", 32'(WB_control_out), 32'd0);
                check("berr_mid", 32'(bus_error), 32'd0);
            end
            dmem_ack = dmem_req && (bc == d);
            dmem_rdata = rd;
            #1;
            s = stall;
            if (dmem_req) begin
                if (bc == 0) begin
                    check("req_we", 32'(dmem_we), 32'(m[0]));
                    check("req_addr", dmem_addr, addr);
                    check("req_wdata", dmem_wdata, data);
                end
                bc++;
            end
            if (s) st++;
            n++;
            @(posedge clk);
        end while (s && n < 300);
        #1;
        dmem_ack = 0;
        check("stall_cycles", st, exp_st);
        check("bus_error", 32'(bus_error), 32'(bad));
        check("req_after", 32'(dmem_req), 32'd0);
        check("wb_out", 32'(WB_control_out), bad ? 32'd0 : 32'(wb));
        if (!bad) begin
            check("alu_out", ALU_out_out, addr);
            check("rw_out", 32'(rw_out), 32'(rw));
            check("mem_data", mem_data_out, (ok && m[1]) ? rd : 32'd0);
        end
    endtask

    initial begin
        logic [31:0] a;
        reset = 1; M_control_in = 2'b10; WB_control_in = 2'b11; ALU_out_in = 32'h100;
        data_write_in = 0; rw_in = 5'd3; dmem_ack = 0; dmem_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_req", 32'(dmem_req), 32'd0);
        check("rst_wb", 32'(WB_control_out), 32'd0);
        check("rst_alu", ALU_out_out, 32'd0);
        check("rst_berr", 32'(bus_error), 32'd0);
        M_control_in = 2'b00;
        @(negedge clk);
        reset = 0;
        issue(2'b00, 2'b10, 32'h1234, 32'h0, 5'd7, 0, 32'h0);
        issue(2'b10, 2'b11, 32'h100, 32'h0, 5'd9, 3, 32'hDEADBEEF);
        issue(2'b01, 2'b00, 32'h20, 32'hCAFE, 5'd0, 0, 32'h0);
        issue(2'b10, 2'b11, 32'h102, 32'h0, 5'd4, 0, 32'h0);
        issue(2'b11, 2'b11, 32'h200, 32'h0, 5'd4, 0, 32'h0);
        issue(2'b10, 2'b11, 32'h300, 32'h0, 5'd5, 99, 32'h0);
        @(negedge clk);
        M_control_in = 2'b00; dmem_ack = 1; dmem_rdata = 32'h5555AAAA;
        @(posedge clk); #1;
        check("stray_ack_req", 32'(dmem_req), 32'd0);
        check("stray_ack_berr", 32'(bus_error), 32'd0);
        check("stray_ack_data", mem_data_out, 32'd0);
        dmem_ack = 0;
        @(negedge clk);
        M_control_in = 2'b10; WB_control_in = 2'b11; ALU_out_in = 32'h400; rw_in = 5'd6;
        repeat (2) @(negedge clk);
        check("busy_req", 32'(dmem_req), 32'd1);
        reset = 1; M_control_in = 2'b00;
        @(posedge clk); #1;
        check("rbusy_req", 32'(dmem_req), 32'd0);
        check("rbusy_berr", 32'(bus_error), 32'd0);
        check("rbusy_wb", 32'(WB_control_out), 32'd0);
        check("rbusy_stall", 32'(stall), 32'd0);
        @(negedge clk);
        reset = 0;
        issue(2'b10, 2'b11, 32'h400, 32'h0, 5'd6, 1, 32'h01234567);
        for (int i = 0; i < 200; i++) begin
            a = $urandom;
            a[1:0] = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            issue(2'($urandom), 2'($urandom), a, $urandom, 5'($urandom), $urandom_range(0, 5), $urandom);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
